// File: rtl/vm_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vm_multi                                                             |
// | Multi-product vending controller; change is planned against the coin |
// | inventory before vending. Optional: VM_TIMEOUT_EN (idle auto-refund).|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vm_multi #(
  parameter int NUM_PRODUCTS   = 4,
  parameter int CREDIT_W       = 10,
  parameter int COUNT_W        = 8,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int SEL_W         = $clog2(NUM_PRODUCTS)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  output logic                coin_reject,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_id,
  input  logic                cancel,
  input  logic                price_we,
  input  logic [SEL_W-1:0]    price_addr,
  input  logic [CREDIT_W-1:0] price_data,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                vend_valid,
  output logic [SEL_W-1:0]    vend_id,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic                err_no_change,
  output logic                err_bad_sel,
  output logic                err_short,
  output logic [COUNT_W-1:0]  inv_25,
  output logic [COUNT_W-1:0]  inv_50,
  output logic [COUNT_W-1:0]  inv_100
);

  localparam logic [CREDIT_W-1:0] c_v25   = CREDIT_W'(25);
  localparam logic [CREDIT_W-1:0] c_v50   = CREDIT_W'(50);
  localparam logic [CREDIT_W-1:0] c_v100  = CREDIT_W'(100);
  localparam logic [SEL_W:0]      c_nprod = (SEL_W+1)'(NUM_PRODUCTS);
  localparam logic [COUNT_W-1:0]  c_one   = COUNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CREDIT   = 3'd1,
    S_CHECK    = 3'd2,
    S_DISPENSE = 3'd3,
    S_REFUND   = 3'd4
  } state_t;

  state_t              r_state;
  logic [CREDIT_W-1:0] r_price [NUM_PRODUCTS];
  logic [SEL_W-1:0]    r_sel;
  logic [CREDIT_W-1:0] r_rem;
  logic [COUNT_W-1:0]  r_sh_25, r_sh_50, r_sh_100;
  logic [COUNT_W-1:0]  r_plan_25, r_plan_50, r_plan_100;
  logic [COUNT_W-1:0]  r_ins_25, r_ins_50, r_ins_100;

  logic [CREDIT_W-1:0] w_coin_value;
  logic [CREDIT_W:0]   w_coin_sum;
  logic                w_inv_sat;
  logic                w_open;
  logic                w_coin_ok;
  logic                w_sel_in;
  logic [CREDIT_W-1:0] w_sel_price;
  logic                w_sel_ok;
  logic                w_paddr_ok;
  logic                w_timeout;

  always_comb begin
    w_coin_value = '0;
    w_inv_sat    = 1'b0;
    case (coin_type)
      2'd0:    begin w_coin_value = c_v25;  w_inv_sat = &inv_25;  end
      2'd1:    begin w_coin_value = c_v50;  w_inv_sat = &inv_50;  end
      2'd2:    begin w_coin_value = c_v100; w_inv_sat = &inv_100; end
      default: begin w_coin_value = '0;     w_inv_sat = 1'b0;     end
    endcase
  end

  assign w_coin_sum = {1'b0, credit} + {1'b0, w_coin_value};
  assign w_open     = (r_state == S_IDLE) || (r_state == S_CREDIT);

  // In CREDIT a coin loses to a concurrent cancel or selection.
  assign w_coin_ok = coin_valid && (coin_type != 2'd3) && !w_coin_sum[CREDIT_W] &&
                     !w_inv_sat && w_open &&
                     !((r_state == S_CREDIT) && (cancel || sel_valid));

  assign w_sel_in    = {1'b0, sel_id} < c_nprod;
  assign w_sel_price = w_sel_in ? r_price[sel_id] : '0;
  assign w_sel_ok    = w_sel_in && (w_sel_price != '0);
  assign w_paddr_ok  = {1'b0, price_addr} < c_nprod;

`ifdef VM_TIMEOUT_EN
  localparam int                c_to_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_to_w-1:0] c_to_one  = c_to_w'(1);

  logic [c_to_w-1:0] r_idle_cnt;

  assign w_timeout = (r_state == S_CREDIT) && !coin_valid && !sel_valid &&
                     (r_idle_cnt == c_to_last);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_idle_cnt <= '0;
    end else if ((r_state != S_CREDIT) || coin_valid || sel_valid || w_timeout) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + c_to_one;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      for (int i = 0; i < NUM_PRODUCTS; i++) r_price[i] <= '0;
      r_sel         <= '0;
      r_rem         <= '0;
      r_sh_25       <= '0;
      r_sh_50       <= '0;
      r_sh_100      <= '0;
      r_plan_25     <= '0;
      r_plan_50     <= '0;
      r_plan_100    <= '0;
      r_ins_25      <= '0;
      r_ins_50      <= '0;
      r_ins_100     <= '0;
      coin_reject   <= 1'b0;
      credit        <= '0;
      busy          <= 1'b0;
      vend_valid    <= 1'b0;
      vend_id       <= '0;
      change_valid  <= 1'b0;
      change_coin   <= 2'd0;
      err_no_change <= 1'b0;
      err_bad_sel   <= 1'b0;
      err_short     <= 1'b0;
      inv_25        <= '0;
      inv_50        <= '0;
      inv_100       <= '0;
    end else begin
      coin_reject   <= coin_valid && !w_coin_ok;
      vend_valid    <= 1'b0;
      change_valid  <= 1'b0;
      err_no_change <= 1'b0;
      err_bad_sel   <= 1'b0;
      err_short     <= 1'b0;

      if (price_we && w_paddr_ok) r_price[price_addr] <= price_data;

      if (w_coin_ok) begin
        credit <= w_coin_sum[CREDIT_W-1:0];
        case (coin_type)
          2'd0:    begin inv_25  <= inv_25  + c_one; r_ins_25  <= r_ins_25  + c_one; end
          2'd1:    begin inv_50  <= inv_50  + c_one; r_ins_50  <= r_ins_50  + c_one; end
          default: begin inv_100 <= inv_100 + c_one; r_ins_100 <= r_ins_100 + c_one; end
        endcase
      end

      case (r_state)
        S_IDLE: begin
          if (w_coin_ok) r_state <= S_CREDIT;
        end

        S_CREDIT: begin
          if (cancel || w_timeout) begin
            r_state <= S_REFUND;
            busy    <= 1'b1;
          end else if (sel_valid) begin
            if (!w_sel_ok) begin
              err_bad_sel <= 1'b1;
            end else if (credit < w_sel_price) begin
              err_short <= 1'b1;
            end else begin
              r_sel      <= sel_id;
              r_rem      <= credit - w_sel_price;
              r_sh_25    <= inv_25;
              r_sh_50    <= inv_50;
              r_sh_100   <= inv_100;
              r_plan_25  <= '0;
              r_plan_50  <= '0;
              r_plan_100 <= '0;
              r_state    <= S_CHECK;
              busy       <= 1'b1;
            end
          end
        end

        // Greedy plan, one coin per cycle, against a shadow of the inventory.
        S_CHECK: begin
          if (r_rem == '0) begin
            vend_valid <= 1'b1;
            vend_id    <= r_sel;
            r_state    <= S_DISPENSE;
          end else if ((r_rem >= c_v100) && (r_sh_100 != '0)) begin
            r_rem      <= r_rem - c_v100;
            r_sh_100   <= r_sh_100 - c_one;
            r_plan_100 <= r_plan_100 + c_one;
          end else if ((r_rem >= c_v50) && (r_sh_50 != '0)) begin
            r_rem     <= r_rem - c_v50;
            r_sh_50   <= r_sh_50 - c_one;
            r_plan_50 <= r_plan_50 + c_one;
          end else if ((r_rem >= c_v25) && (r_sh_25 != '0)) begin
            r_rem     <= r_rem - c_v25;
            r_sh_25   <= r_sh_25 - c_one;
            r_plan_25 <= r_plan_25 + c_one;
          end else begin
            err_no_change <= 1'b1;
            r_state       <= S_REFUND;
          end
        end

        S_DISPENSE: begin
          if (r_plan_100 != '0) begin
            change_valid <= 1'b1;
            change_coin  <= 2'd2;
            r_plan_100   <= r_plan_100 - c_one;
            inv_100      <= inv_100 - c_one;
          end else if (r_plan_50 != '0) begin
            change_valid <= 1'b1;
            change_coin  <= 2'd1;
            r_plan_50    <= r_plan_50 - c_one;
            inv_50       <= inv_50 - c_one;
          end else if (r_plan_25 != '0) begin
            change_valid <= 1'b1;
            change_coin  <= 2'd0;
            r_plan_25    <= r_plan_25 - c_one;
            inv_25       <= inv_25 - c_one;
          end else begin
            credit    <= '0;
            r_ins_25  <= '0;
            r_ins_50  <= '0;
            r_ins_100 <= '0;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end

        S_REFUND: begin
          if (r_ins_100 != '0) begin
            change_valid <= 1'b1;
            change_coin  <= 2'd2;
            r_ins_100    <= r_ins_100 - c_one;
            inv_100      <= inv_100 - c_one;
          end else if (r_ins_50 != '0) begin
            change_valid <= 1'b1;
            change_coin  <= 2'd1;
            r_ins_50     <= r_ins_50 - c_one;
            inv_50       <= inv_50 - c_one;
          end else if (r_ins_25 != '0) begin
            change_valid <= 1'b1;
            change_coin  <= 2'd0;
            r_ins_25     <= r_ins_25 - c_one;
            inv_25       <= inv_25 - c_one;
          end else begin
            credit  <= '0;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vm_multi.sv
`default_nettype none
// tb_vm_multi: vector table, directed corner sequences and a randomized run
// checked against a transaction-level model of the vending rules.
module tb_vm_multi;
  localparam int NP   = 4;
  localparam int CW   = 10;
  localparam int KW   = 8;
  localparam int SW   = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam int KMAX = (1 << KW) - 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          coin_valid = 1'b0;
  logic [1:0]    coin_type = 2'd0;
  logic          sel_valid = 1'b0;
  logic [SW-1:0] sel_id = '0;
  logic          cancel = 1'b0;
  logic          price_we = 1'b0;
  logic [SW-1:0] price_addr = '0;
  logic [CW-1:0] price_data = '0;
  logic          coin_reject, busy, vend_valid, change_valid;
  logic          err_no_change, err_bad_sel, err_short;
  logic [CW-1:0] credit;
  logic [SW-1:0] vend_id;
  logic [1:0]    change_coin;
  logic [KW-1:0] inv_25, inv_50, inv_100;

  always #5 clock = ~clock;

  vm_multi #(.NUM_PRODUCTS(NP), .CREDIT_W(CW), .COUNT_W(KW), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset_n(reset_n), .coin_valid(coin_valid), .coin_type(coin_type),
    .coin_reject(coin_reject), .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
    .price_we(price_we), .price_addr(price_addr), .price_data(price_data),
    .credit(credit), .busy(busy), .vend_valid(vend_valid), .vend_id(vend_id),
    .change_valid(change_valid), .change_coin(change_coin), .err_no_change(err_no_change),
    .err_bad_sel(err_bad_sel), .err_short(err_short),
    .inv_25(inv_25), .inv_50(inv_50), .inv_100(inv_100)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- observation ----------------
  int obs_coins[$];
  int vend_cnt, vend_seen_id, vend_cyc, nochg_cnt, first_chg, last_chg;
  int last_rej, sel_short, sel_bad;

  task automatic collect();
    int cyc;
    obs_coins.delete();
    vend_cnt = 0; vend_seen_id = -1; vend_cyc = -1; nochg_cnt = 0;
    first_chg = -1; last_chg = -1; cyc = 0;
    while (busy && cyc < 400) begin
      tick();
      cyc++;
      if (vend_valid) begin vend_cnt++; vend_seen_id = int'(vend_id); vend_cyc = cyc; end
      if (err_no_change) nochg_cnt++;
      if (change_valid) begin
        obs_coins.push_back(int'(change_coin));
        if (first_chg < 0) first_chg = cyc;
        last_chg = cyc;
      end
    end
    check("transaction_done", int'(busy), 0);
  endtask

  task automatic insert(input int t);
    coin_valid = 1'b1;
    coin_type  = t[1:0];
    tick();
    coin_valid = 1'b0;
    last_rej   = int'(coin_reject);
  endtask

  task automatic select(input int id);
    sel_valid = 1'b1;
    sel_id    = id[SW-1:0];
    tick();
    sel_valid = 1'b0;
    sel_short = int'(err_short);
    sel_bad   = int'(err_bad_sel);
  endtask

  task automatic set_price(input int id, input int p);
    price_we   = 1'b1;
    price_addr = id[SW-1:0];
    price_data = p[CW-1:0];
    tick();
    price_we   = 1'b0;
  endtask

  task automatic do_reset();
    coin_valid = 0; sel_valid = 0; cancel = 0; price_we = 0;
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_vend();
    int n;
    n = 0;
    while (!vend_valid && n < 50) begin tick(); n++; end
    check("wait_vend", int'(vend_valid), 1);
  endtask

  task automatic check_inv(input string p, input int e25, input int e50, input int e100, input int ecr);
    check({p, "_inv25"}, int'(inv_25), e25);
    check({p, "_inv50"}, int'(inv_50), e50);
    check({p, "_inv100"}, int'(inv_100), e100);
    check({p, "_credit"}, int'(credit), ecr);
  endtask

  // ---------------- reference model ----------------
  int m_credit;
  int m_inv[3];
  int m_ins[3];
  int m_price[NP];
  int e_q[$];
  int e_vend, e_id, e_nochg, e_short, e_bad;

  function automatic int cval(input int t);
    return (t == 0) ? 25 : (t == 1) ? 50 : (t == 2) ? 100 : 0;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic m_reset();
    m_credit = 0;
    for (int c = 0; c < 3; c++) begin m_inv[c] = 0; m_ins[c] = 0; end
    for (int i = 0; i < NP; i++) m_price[i] = 0;
  endtask

  task automatic m_coin(input int t, output int rej);
    rej = 1;
    if (t != 3) begin
      if (m_credit + cval(t) <= CMAX && m_inv[t] < KMAX) begin
        rej = 0;
        m_credit += cval(t);
        m_inv[t]++;
        m_ins[t]++;
      end
    end
  endtask

  task automatic m_pay(input int n2, input int n1, input int n0);
    for (int j = 0; j < n2; j++) e_q.push_back(2);
    for (int j = 0; j < n1; j++) e_q.push_back(1);
    for (int j = 0; j < n0; j++) e_q.push_back(0);
    m_inv[2] -= n2; m_inv[1] -= n1; m_inv[0] -= n0;
    m_credit = 0;
    for (int c = 0; c < 3; c++) m_ins[c] = 0;
  endtask

  task automatic m_clear_exp(input int id);
    e_q.delete();
    e_vend = 0; e_id = id; e_nochg = 0; e_short = 0; e_bad = 0;
  endtask

  task automatic m_select(input int id);
    int rem, n2, n1, n0;
    m_clear_exp(id);
    if (m_price[id] == 0) e_bad = 1;
    else if (m_credit < m_price[id]) e_short = 1;
    else begin
      rem = m_credit - m_price[id];
      n2 = imin(rem / 100, m_inv[2]); rem -= 100 * n2;
      n1 = imin(rem / 50,  m_inv[1]); rem -= 50 * n1;
      n0 = imin(rem / 25,  m_inv[0]); rem -= 25 * n0;
      if (rem == 0) begin
        e_vend = 1;
        m_pay(n2, n1, n0);
      end else begin
        e_nochg = 1;
        m_pay(m_ins[2], m_ins[1], m_ins[0]);
      end
    end
  endtask

  task automatic compare_outcome(input string p);
    check({p, "_vend"}, vend_cnt, e_vend);
    if (e_vend != 0) check({p, "_vend_id"}, vend_seen_id, e_id);
    check({p, "_no_change"}, nochg_cnt, e_nochg);
    check({p, "_ncoins"}, obs_coins.size(), e_q.size());
    for (int i = 0; i < e_q.size() && i < obs_coins.size(); i++)
      check({p, "_coin"}, obs_coins[i], e_q[i]);
    check_inv(p, m_inv[0], m_inv[1], m_inv[2], m_credit);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit cv; int ct; bit sv; int sid;
    int exp_credit; bit exp_rej; bit exp_short; bit exp_bad;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rej, exp_q[$];
    vecs[0] = '{1, 1, 0, 0,  50, 0, 0, 0};  // 50 accepted
    vecs[1] = '{0, 0, 1, 2,  50, 0, 1, 0};  // price 100 > 50
    vecs[2] = '{0, 0, 1, 3,  50, 0, 0, 1};  // price 0
    vecs[3] = '{1, 3, 0, 0,  50, 1, 0, 0};  // invalid coin code
    vecs[4] = '{1, 0, 0, 0,  75, 0, 0, 0};  // 25 accepted
    vecs[5] = '{1, 0, 1, 2,  75, 1, 1, 0};  // selection beats coin

    do_reset();
    check("rst_credit", int'(credit), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_vend", int'(vend_valid), 0);
    check("rst_change", int'(change_valid), 0);
    check("rst_reject", int'(coin_reject), 0);
    check_inv("rst", 0, 0, 0, 0);

    // cancel with no credit is ignored
    cancel = 1'b1; tick(); cancel = 1'b0;
    tick();
    check("idle_cancel_busy", int'(busy), 0);
    check("idle_cancel_change", int'(change_valid), 0);

    set_price(0, 25); set_price(1, 75); set_price(2, 100); set_price(3, 0);
    foreach (vecs[i]) begin
      coin_valid = vecs[i].cv; coin_type = vecs[i].ct[1:0];
      sel_valid  = vecs[i].sv; sel_id    = vecs[i].sid[SW-1:0];
      tick();
      coin_valid = 1'b0; sel_valid = 1'b0;
      check($sformatf("vec%0d_credit", i), int'(credit), vecs[i].exp_credit);
      check($sformatf("vec%0d_reject", i), int'(coin_reject), int'(vecs[i].exp_rej));
      check($sformatf("vec%0d_short", i), int'(err_short), int'(vecs[i].exp_short));
      check($sformatf("vec%0d_bad_sel", i), int'(err_bad_sel), int'(vecs[i].exp_bad));
    end

    // cancel and coin together: coin returned, earlier 50+25 refunded
    cancel = 1'b1; coin_valid = 1'b1; coin_type = 2'd2;
    tick();
    cancel = 1'b0; coin_valid = 1'b0;
    check("cancel_coin_reject", int'(coin_reject), 1);
    collect();
    check("cancel_ncoins", obs_coins.size(), 2);
    if (obs_coins.size() == 2) begin
      check("cancel_coin0", obs_coins[0], 1);
      check("cancel_coin1", obs_coins[1], 0);
    end
    check_inv("cancel", 0, 0, 0, 0);

    // exact change path
    do_reset();
    set_price(1, 75);
    insert(1); insert(0); insert(0); insert(2);
    check("exact_credit", int'(credit), 200);
    select(1);
    collect();
    check("exact_vend", vend_cnt, 1);
    check("exact_vend_id", vend_seen_id, 1);
    check("exact_vend_cycle", vend_cyc, 3);
    check("exact_first_change_cycle", first_chg, 4);
    check("exact_last_change_cycle", last_chg, 5);
    exp_q = '{2, 0};
    check("exact_ncoins", obs_coins.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_coins.size(); i++)
      check("exact_coin", obs_coins[i], exp_q[i]);
    check_inv("exact", 1, 1, 0, 0);

    // no change possible: refund the customer's 100
    do_reset();
    set_price(1, 75);
    insert(2);
    select(1);
    collect();
    check("nochg_err", nochg_cnt, 1);
    check("nochg_vend", vend_cnt, 0);
    check("nochg_ncoins", obs_coins.size(), 1);
    if (obs_coins.size() == 1) check("nochg_coin", obs_coins[0], 2);
    check_inv("nochg", 0, 0, 0, 0);

    // coin during DISPENSE is returned and inventory is not touched
    do_reset();
    set_price(1, 75);
    insert(1); insert(0); insert(0); insert(2);
    select(1);
    wait_vend();
    insert(0);
    check("busy_coin_reject", last_rej, 1);
    collect();
    check_inv("busy_coin", 1, 1, 0, 0);

    // credit saturation at 1000
    do_reset();
    for (int i = 0; i < 10; i++) insert(2);
    check("sat_credit", int'(credit), 1000);
    insert(2);
    check("sat_reject100", last_rej, 1);
    insert(0);
    check("sat_reject25", last_rej, 1);
    check("sat_credit_after", int'(credit), 1000);
    check("sat_inv100", int'(inv_100), 10);

    // reset mid-DISPENSE
    do_reset();
    set_price(1, 75);
    insert(1); insert(0); insert(0); insert(2);
    select(1);
    wait_vend();
    reset_n = 1'b0;
    tick();
    check("midrst_busy", int'(busy), 0);
    check("midrst_vend", int'(vend_valid), 0);
    check("midrst_change", int'(change_valid), 0);
    check_inv("midrst", 0, 0, 0, 0);
    reset_n = 1'b1;
    tick();

`ifdef VM_TIMEOUT_EN
    do_reset();
    insert(0);
    for (int i = 0; i < 7; i++) tick();
    check("timeout_not_yet", int'(busy), 0);
    tick();
    check("timeout_refund_busy", int'(busy), 1);
    collect();
    check("timeout_ncoins", obs_coins.size(), 1);
    if (obs_coins.size() == 1) check("timeout_coin", obs_coins[0], 0);
    check_inv("timeout", 0, 0, 0, 0);
`endif

    // randomized transactions against the model
    do_reset();
    m_reset();
    for (int i = 0; i < NP; i++) begin
      int r;
      r = $urandom_range(0, 6);
      m_price[i] = (r == 0) ? 0 : (r == 6) ? 25 * $urandom_range(1, 6) + 10 : 25 * $urandom_range(1, 8);
      set_price(i, m_price[i]);
    end
    for (int tr = 0; tr < 60; tr++) begin
      int nc, act, id;
      nc = $urandom_range(1, 4);
      for (int k = 0; k < nc; k++) begin
        int t;
        t = $urandom_range(0, 3);
        m_coin(t, rej);
        insert(t);
        check("rnd_reject", last_rej, rej);
        check("rnd_credit", int'(credit), m_credit);
      end
      if (m_credit != 0) begin
        act = $urandom_range(0, 9);
        if (act == 0) begin
          m_clear_exp(0);
          m_pay(m_ins[2], m_ins[1], m_ins[0]);
          cancel = 1'b1; tick(); cancel = 1'b0;
          collect();
          compare_outcome("rnd_cancel");
        end else begin
          id = $urandom_range(0, NP - 1);
          m_select(id);
          select(id);
          check("rnd_short", sel_short, e_short);
          check("rnd_bad_sel", sel_bad, e_bad);
          collect();
          compare_outcome("rnd_sel");
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vm_multi.md
# vm_multi

Parametrised multi-product vending controller. Successor to the single-product, three-price machine. Supports NUM_PRODUCTS runtime-programmable prices and a tracked coin inventory of 25/50/100 units. Change is planned against that inventory before anything is committed, so the block either vends and pays exact change, or vends nothing and refunds the customer's own coins. It sits between the coin acceptor front end and the product/coin dispenser drivers.

## Interface
- NUM_PRODUCTS, 4, number of product slots (≥2); SEL_W = $clog2(NUM_PRODUCTS)
- CREDIT_W, 10, width of credit, price and change arithmetic
- COUNT_W, 8, width of each coin inventory counter
- TIMEOUT_CYCLES, 1000, idle cycles before auto-refund (used only with VM_TIMEOUT_EN)

- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- coin_valid  in  1  one-cycle coin strobe
- coin_type  in  2  coin value code: 0=25, 1=50, 2=100, 3=invalid
- coin_reject  out  1  one-cycle pulse: the coin is returned and not counted
- sel_valid  in  1  one-cycle selection strobe
- sel_id  in  SEL_W  product index
- cancel  in  1  one-cycle refund request
- price_we  in  1  price table write enable
- price_addr  in  SEL_W  price table write index
- price_data  in  CREDIT_W  price value; 0 = slot unavailable
- credit  out  CREDIT_W  current transaction credit
- busy  out  1  high in CHECK, DISPENSE and REFUND
- vend_valid  out  1  one-cycle vend pulse
- vend_id  out  SEL_W  product index, valid with vend_valid
- change_valid  out  1  one-cycle pulse per coin paid out
- change_coin  out  2  coin code, valid with change_valid
- err_no_change  out  1  pulse: exact change is impossible; refund follows
- err_bad_sel  out  1  pulse: index out of range or price is 0
- err_short  out  1  pulse: credit is below price; selection ignored
- inv_25, inv_50, inv_100  out  COUNT_W  coin inventory counts

## Operation
- States: IDLE, CREDIT, CHECK, DISPENSE, REFUND.
- Reset: all outputs 0, inventory 0, all prices 0, per-transaction inserted counts 0, state IDLE.
- Accepted coin: add its value to credit, increment its inventory counter and increment its per-transaction inserted counter. IDLE→CREDIT on the first accepted coin.
- A coin is rejected (coin_reject, no state change) if any of the following holds:
  - coin_type=3
  - credit+value exceeds 2^CREDIT_W−1
  - its inventory counter is saturated
  - busy=1
- Priority within one cycle in CREDIT is cancel > sel_valid > coin_valid. A coin that loses priority is rejected. A selection that loses priority is dropped.
- cancel in CREDIT → REFUND.
- sel_valid in CREDIT:
  - bad index or zero price → err_bad_sel, stay in CREDIT.
  - credit < price → err_short, stay in CREDIT.
  - otherwise latch price and sel_id, set rem = credit − price, copy inventory into shadow counts, go to CHECK.
- CHECK plans one coin per cycle, greedily: 100 if rem≥100 and shadow_100>0, else 50, else 25. The chosen shadow count is decremented and the planned count incremented.
  - rem=0 → DISPENSE.
  - No coin fits and rem>0 → pulse err_no_change, go to REFUND.
- Greedy selection is exact for the 25|50|100 chain.
- DISPENSE:
  - First cycle: vend_valid with vend_id.
  - Then one change coin per cycle, 100s first, then 50s, then 25s. Each paid coin decrements its inventory counter.
  - When done: credit=0, inserted counts cleared, → IDLE.
- REFUND pays back exactly the per-transaction inserted coins, one per cycle, in the same order and decrementing inventory. Then credit=0, inserted counts cleared, → IDLE.
- cancel with credit=0 in IDLE: ignored.
- price_we writes the price table in any state. A transaction already past CHECK entry keeps its latched price.
- Reset asserted mid-transaction: immediate return to reset state. No refund is owed.

## Timing
- Coin strobe at edge t → credit and inventory updated at edge t+1.
- coin_reject is asserted in the cycle after the strobe.
- sel_valid at t → CHECK from t+1. CHECK takes k+1 cycles for k planned coins. vend_valid comes in the first DISPENSE cycle; change coins follow back-to-back.
- err_* and coin_reject pulse in the cycle after the triggering strobe.
- All outputs are registered.

## Configuration
- VM_TIMEOUT_EN defined:
  - An idle counter runs in CREDIT. It resets on every accepted coin, rejected coin and selection strobe.
  - Reaching TIMEOUT_CYCLES forces CREDIT→REFUND, exactly as cancel does.
- Undefined: no counter is built, CREDIT waits indefinitely, and TIMEOUT_CYCLES is ignored.

## Test plan
- Exact change path:
  - Stimulus: price[1]=75; from reset insert 50, 25, 25, 100 (credit=200); sel_id=1.
  - Response: vend_valid with vend_id=1, then change_coin 2 then 0 (125 in change).
  - Final state: inv_25=1, inv_50=1, inv_100=0, credit=0.
- No-change refund:
  - Stimulus: price[1]=75; from reset insert 100; sel_id=1.
  - Response: err_no_change, no vend_valid, change_coin=2 refunded.
  - Final state: inv_100=0, IDLE.
- Selection errors: price[2]=100, credit=50 → err_short and credit stays 50. sel_id=3 with price[3]=0 → err_bad_sel.
- Priority and busy rejection:
  - cancel and coin_valid in the same cycle → coin_reject and a refund of the earlier coins.
  - A coin during DISPENSE → coin_reject, with inventory unchanged.
- Saturation and reset:
  - credit=1000 with CREDIT_W=10, insert 100 → coin_reject.
  - reset_n low mid-DISPENSE → all outputs 0 on the next cycle.
- Timeout: VM_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, insert 25, then idle 8 cycles → REFUND pays change_coin=0.
